// File: rtl/pc_sequencer.sv
// pc_sequencer: TinyCPU program-counter sequencer.
// Owns the PC register and computes the next PC internally. Supported operations:
// sequential advance, conditional jump, call, and return.
// Optional feature macro PC_RAS_EN adds a hardware return-address stack (RAS).
//   - With the macro undefined, CALL is a plain jump and RET behaves as SEQ.
//   - The RAS status outputs are then tied to zero.

`ifndef STAGE_WIDTH
`define STAGE_WIDTH 2
`endif
`ifndef STAGE_FETCH
`define STAGE_FETCH 2'd0
`endif

module pc_sequencer #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    PC_INCR    = 1,
    parameter int                    RAS_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [`STAGE_WIDTH-1:0]      stage,
    input  logic                         stall,
    input  logic [2:0]                   pc_op,
    input  logic                         jump_cond,
    input  logic [ADDR_WIDTH-1:0]        target,
    output logic [ADDR_WIDTH-1:0]        pc,
    output logic [ADDR_WIDTH-1:0]        pc_next,
    output logic                         pc_en,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam logic [2:0] OP_SEQ  = 3'd0;
    localparam logic [2:0] OP_JUMP = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] seq;

    assign seq   = pc_q + ADDR_WIDTH'(PC_INCR);
    assign pc_en = (stage == `STAGE_FETCH) && !stall;
    assign pc    = pc_q;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      top_idx;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  ras_empty;
    logic                  ras_full;

    // The pointer addresses the next free slot, so the newest entry sits one below it.
    assign top_idx   = ptr_q - PTR_W'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));

    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
`else
    assign ras_count     = '0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    // Select the candidate PC for the current operation.
    always_comb begin
        pc_next = seq;
        case (pc_op)
            OP_SEQ:  pc_next = seq;
            OP_JUMP: pc_next = jump_cond ? target : seq;
            OP_CALL: pc_next = target;
`ifdef PC_RAS_EN
            OP_RET:  pc_next = ras_empty ? seq : ras_mem_q[top_idx];
`else
            OP_RET:  pc_next = seq;
`endif
            default: pc_next = pc_q;
        endcase
    end

    // Commit the candidate PC only on update cycles.
    always_comb begin
        pc_d = pc_en ? pc_next : pc_q;
    end

`ifdef PC_RAS_EN
    // RAS pointer, occupancy and sticky flags for push (CALL) and pop (RET).
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (pc_en) begin
            if (pc_op == OP_CALL) begin
                ptr_d = ptr_q + PTR_W'(1);
                if (ras_full) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (pc_op == OP_RET) begin
                if (ras_empty) begin
                    unf_d = 1'b1;
                end else begin
                    ptr_d = ptr_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        end
    end

    // RAS storage: a push writes the return address into the free slot.
    // When the stack is full, this slot holds the oldest entry, which is overwritten.
    always_ff @(posedge clk) begin
        if (!rst && pc_en && (pc_op == OP_CALL)) begin
            ras_mem_q[ptr_q] <= seq;
        end
    end

    // RAS control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
`endif

    // PC register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer.
// Stimulus is checked against a behavioural model. The model keeps the return stack
// as a bounded queue; when it grows past its depth, the oldest entry is dropped.
// The model follows PC_RAS_EN in the same way as the design.

`ifndef STAGE_WIDTH
`define STAGE_WIDTH 2
`endif
`ifndef STAGE_FETCH
`define STAGE_FETCH 2'd0
`endif

module tb_pc_sequencer;

    localparam int          AW      = 32;
    localparam logic [31:0] RST_PC  = 32'h100;
    localparam int          INCR    = 1;
    localparam int          DEPTH   = 4;
`ifdef PC_RAS_EN
    localparam bit          RAS_ON  = 1'b1;
`else
    localparam bit          RAS_ON  = 1'b0;
`endif

    localparam logic [2:0] SEQ  = 3'd0;
    localparam logic [2:0] JUMP = 3'd1;
    localparam logic [2:0] CALL = 3'd2;
    localparam logic [2:0] RET  = 3'd3;
    localparam logic [1:0] FETCH = `STAGE_FETCH;

    logic                    clk;
    logic                    rst;
    logic [`STAGE_WIDTH-1:0] stage;
    logic                    stall;
    logic [2:0]              pc_op;
    logic                    jump_cond;
    logic [AW-1:0]           target;
    logic [AW-1:0]           pc;
    logic [AW-1:0]           pc_next;
    logic                    pc_en;
    logic [2:0]              ras_count;
    logic                    ras_overflow;
    logic                    ras_underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_ovf;
    logic        m_unf;

    // Values captured during the last driven cycle, before the clock edge
    logic [31:0] exp_next;
    logic [31:0] obs_next;
    logic        exp_en;
    logic        obs_en;

    pc_sequencer #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (RST_PC),
        .PC_INCR   (INCR),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stage        (stage),
        .stall        (stall),
        .pc_op        (pc_op),
        .jump_cond    (jump_cond),
        .target       (target),
        .pc           (pc),
        .pc_next      (pc_next),
        .pc_en        (pc_en),
        .ras_count    (ras_count),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_next(input logic [2:0] op, input logic c,
                                               input logic [31:0] t);
        logic [31:0] s;
        s = m_pc + 32'(INCR);
        case (op)
            SEQ:     return s;
            JUMP:    return c ? t : s;
            CALL:    return t;
            RET:     return (RAS_ON && m_ras.size() != 0) ? m_ras[$] : s;
            default: return m_pc;
        endcase
    endfunction

    // Drive one cycle and advance the model.
    // pc_next and pc_en are captured before the edge; comparisons are made by the callers.
    task automatic drive_cycle(input logic [2:0] op, input logic c, input logic [31:0] t,
                               input logic [1:0] st, input logic sl);
        logic [31:0] s;
        logic [31:0] nxt;
        rst = 1'b0; pc_op = op; jump_cond = c; target = t; stage = st; stall = sl;
        #1;
        exp_next = model_next(op, c, t);
        exp_en   = (st == FETCH) && !sl;
        obs_next = pc_next;
        obs_en   = pc_en;
        @(posedge clk);
        if (exp_en) begin
            s   = m_pc + 32'(INCR);
            nxt = model_next(op, c, t);
            if (RAS_ON && op == CALL) begin
                m_ras.push_back(s);
                if (m_ras.size() > DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1'b1;
                end
            end else if (RAS_ON && op == RET) begin
                if (m_ras.size() != 0) void'(m_ras.pop_back());
                else m_unf = 1'b1;
            end
            m_pc = nxt;
        end
        #1;
    endtask

    // Reset with a CALL presented at the same time; reset must win.
    task automatic do_reset();
        rst = 1'b1; pc_op = CALL; jump_cond = 1'b1; target = 32'hDEAD_0000;
        stage = FETCH; stall = 1'b0;
        @(posedge clk);
        m_pc = RST_PC; m_ras.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        rst = 1'b0; pc_op = SEQ;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 32'h100) begin
            errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h100);
        end
        checks++;
        if ({ras_count, ras_overflow, ras_underflow} !== 5'b0) begin
            errors++; $display("FAIL reset_ras: got cnt=%0d ovf=%b unf=%b expected 0 0 0",
                               ras_count, ras_overflow, ras_underflow);
        end
        stage = FETCH; stall = 1'b0; pc_op = SEQ; #1;
        checks++;
        if (pc_next !== 32'h101) begin
            errors++; $display("FAIL reset_pc_next: got %h expected %h", pc_next, 32'h101);
        end
        repeat (3) drive_cycle(SEQ, 1'b0, 32'h0, FETCH, 1'b0);
        checks++;
        if (pc !== 32'h103) begin
            errors++; $display("FAIL seq_x3: got %h expected %h", pc, 32'h103);
        end
        $display("test_reset: pc=%h", pc);
    endtask

    task automatic test_jump();
        drive_cycle(JUMP, 1'b1, 32'h40, FETCH, 1'b0);
        checks++;
        if (pc !== 32'h40) begin
            errors++; $display("FAIL jump_taken: got %h expected %h", pc, 32'h40);
        end
        drive_cycle(JUMP, 1'b0, 32'h99, FETCH, 1'b0);
        checks++;
        if (pc !== 32'h41) begin
            errors++; $display("FAIL jump_not_taken: got %h expected %h", pc, 32'h41);
        end
        drive_cycle(JUMP, 1'b1, 32'hFFFF_FFFF, FETCH, 1'b0);
        drive_cycle(SEQ, 1'b0, 32'h0, FETCH, 1'b0);
        checks++;
        if (obs_next !== 32'h0) begin
            errors++; $display("FAIL wrap_pc_next: got %h expected %h", obs_next, 32'h0);
        end
        checks++;
        if (pc !== 32'h0) begin
            errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0);
        end
        $display("test_jump: pc=%h", pc);
    endtask

    task automatic test_gating();
        drive_cycle(JUMP, 1'b1, 32'h10, FETCH, 1'b0);
        drive_cycle(CALL, 1'b0, 32'h80, FETCH, 1'b1);
        checks++;
        if (obs_en !== 1'b0) begin
            errors++; $display("FAIL stall_pc_en: got %b expected 0", obs_en);
        end
        checks++;
        if (obs_next !== 32'h80) begin
            errors++; $display("FAIL stall_pc_next: got %h expected %h", obs_next, 32'h80);
        end
        checks++;
        if (pc !== 32'h10 || ras_count !== 3'd0) begin
            errors++; $display("FAIL stall_hold: got pc=%h cnt=%0d expected pc=10 cnt=0",
                               pc, ras_count);
        end
        drive_cycle(CALL, 1'b0, 32'h80, 2'd1, 1'b0);
        checks++;
        if (obs_en !== 1'b0) begin
            errors++; $display("FAIL stage_pc_en: got %b expected 0", obs_en);
        end
        checks++;
        if (pc !== 32'h10 || ras_count !== 3'd0) begin
            errors++; $display("FAIL stage_hold: got pc=%h cnt=%0d expected pc=10 cnt=0",
                               pc, ras_count);
        end
        $display("test_gating: pc=%h cnt=%0d", pc, ras_count);
    endtask

    task automatic test_nested();
        drive_cycle(CALL, 1'b0, 32'h80, FETCH, 1'b0);
        drive_cycle(CALL, 1'b0, 32'hC0, FETCH, 1'b0);
        checks++;
        if (ras_count !== 3'(m_ras.size())) begin
            errors++; $display("FAIL nested_count: got %0d expected %0d", ras_count, m_ras.size());
        end
        // RET right after a CALL: no read-after-write bubble
        drive_cycle(RET, 1'b0, 32'h0, FETCH, 1'b0);
        checks++;
        if (pc !== m_pc) begin
            errors++; $display("FAIL nested_ret1: got %h expected %h", pc, m_pc);
        end
        drive_cycle(RET, 1'b0, 32'h0, FETCH, 1'b0);
        checks++;
        if (pc !== m_pc) begin
            errors++; $display("FAIL nested_ret2: got %h expected %h", pc, m_pc);
        end
`ifdef PC_RAS_EN
        checks++;
        if (pc !== 32'h11 || ras_count !== 3'd0) begin
            errors++; $display("FAIL nested_final: got pc=%h cnt=%0d expected pc=11 cnt=0",
                               pc, ras_count);
        end
`else
        checks++;
        if (pc !== 32'hC2 || ras_count !== 3'd0) begin
            errors++; $display("FAIL noras_final: got pc=%h cnt=%0d expected pc=c2 cnt=0",
                               pc, ras_count);
        end
`endif
        $display("test_nested: pc=%h cnt=%0d", pc, ras_count);
    endtask

    task automatic test_overflow();
        logic [31:0] ret_exp [4];
        ret_exp[0] = 32'h41; ret_exp[1] = 32'h31; ret_exp[2] = 32'h21; ret_exp[3] = 32'h11;
        do_reset();
        drive_cycle(JUMP, 1'b1, 32'h0, FETCH, 1'b0);
        for (int i = 1; i <= 5; i++) drive_cycle(CALL, 1'b0, 32'(i * 16), FETCH, 1'b0);
        checks++;
        if (ras_overflow !== m_ovf || ras_count !== 3'(m_ras.size())) begin
            errors++; $display("FAIL overflow: got ovf=%b cnt=%0d expected ovf=%b cnt=%0d",
                               ras_overflow, ras_count, m_ovf, m_ras.size());
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle(RET, 1'b0, 32'h0, FETCH, 1'b0);
            checks++;
            if (pc !== (RAS_ON ? ret_exp[i] : m_pc)) begin
                errors++; $display("FAIL ovf_ret%0d: got %h expected %h", i, pc,
                                   RAS_ON ? ret_exp[i] : m_pc);
            end
        end
        drive_cycle(RET, 1'b0, 32'h0, FETCH, 1'b0);
        checks++;
        if (pc !== m_pc || ras_underflow !== m_unf) begin
            errors++; $display("FAIL underflow: got pc=%h unf=%b expected pc=%h unf=%b",
                               pc, ras_underflow, m_pc, m_unf);
        end
        do_reset();
        checks++;
        if (ras_overflow !== 1'b0 || ras_underflow !== 1'b0) begin
            errors++; $display("FAIL flags_clear: got ovf=%b unf=%b expected 0 0",
                               ras_overflow, ras_underflow);
        end
        $display("test_overflow: pc=%h", pc);
    endtask

    task automatic test_random();
        int n_cyc = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive_cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                            (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : {$urandom} & 32'hFF),
                            ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : FETCH,
                            ($urandom_range(0, 5) == 0));
                n_cyc++;
                checks++;
                if (obs_next !== exp_next || obs_en !== exp_en) begin
                    errors++; $display("FAIL rand_comb[%0d]: got next=%h en=%b expected next=%h en=%b",
                                       i, obs_next, obs_en, exp_next, exp_en);
                end
            end
            checks++;
            if (pc !== m_pc || ras_count !== 3'(m_ras.size()) ||
                ras_overflow !== m_ovf || ras_underflow !== m_unf) begin
                errors++; $display("FAIL rand_state[%0d]: got pc=%h cnt=%0d ovf=%b unf=%b expected pc=%h cnt=%0d ovf=%b unf=%b",
                                   i, pc, ras_count, ras_overflow, ras_underflow,
                                   m_pc, m_ras.size(), m_ovf, m_unf);
            end
        end
        $display("test_random: %0d driven cycles", n_cyc);
    endtask

    initial begin
        rst = 1'b1; stage = FETCH; stall = 1'b0; pc_op = SEQ; jump_cond = 1'b0; target = '0;
        m_pc = RST_PC; m_ovf = 1'b0; m_unf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_jump();
        test_gating();
        test_nested();
        test_overflow();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for TinyCPU. It owns the PC register and computes the next PC itself instead of taking it from the ALU. It supports sequential advance, conditional jump, and call/return through an optional hardware return-address stack (RAS). It sits between decode/control and the instruction-memory address port, and updates only in the fetch stage.

## Interface

Parameters:
- `ADDR_WIDTH`, default 32: width of the PC, the target and the RAS entries.
- `RESET_PC`, default 0: PC value loaded on reset.
- `PC_INCR`, default 1: sequential increment; 1 means word-addressed.
- `RAS_DEPTH`, default 4: number of RAS entries; must be a power of two, at least 2.

Ports:
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stage` input `` `STAGE_WIDTH ``: current pipeline stage; updates are allowed only when it equals `` `STAGE_FETCH ``.
- `stall` input 1: when high, suppresses any update.
- `pc_op` input 3: operation select. 0 SEQ, 1 JUMP, 2 CALL, 3 RET, 4–7 HOLD.
- `jump_cond` input 1: JUMP is taken only when this is 1.
- `target` input ADDR_WIDTH: destination for a taken JUMP and for CALL.
- `pc` output ADDR_WIDTH: the registered current PC.
- `pc_next` output ADDR_WIDTH: combinational value `pc` will take if the cycle updates.
- `pc_en` output 1: `stage == STAGE_FETCH && !stall`.
- `ras_count` output clog2(RAS_DEPTH)+1: number of valid RAS entries.
- `ras_overflow` output 1: sticky flag; set when a push happens while the RAS is full.
- `ras_underflow` output 1: sticky flag; set when a RET is issued while the RAS is empty.

## Operation

- Define `seq = pc + PC_INCR`, truncated to ADDR_WIDTH; it wraps modulo 2^ADDR_WIDTH.
- `pc_next` by operation:
  - SEQ: `seq`.
  - JUMP: `jump_cond ? target : seq`.
  - CALL: `target`.
  - RET: RAS top if `ras_count != 0`, otherwise `seq`.
  - HOLD: `pc`.
- Update cycle: `pc_en == 1`. On an update cycle, `pc <= pc_next` and the RAS acts as below. Outside update cycles, nothing changes.
- CALL push:
  - Write `seq` at the top pointer, then increment the pointer modulo RAS_DEPTH.
  - If `ras_count < RAS_DEPTH`, increment `ras_count`.
  - Otherwise the oldest entry is overwritten, `ras_count` stays RAS_DEPTH, and `ras_overflow` is set.
- RET pop:
  - If `ras_count != 0`: decrement the pointer and `ras_count`.
  - If empty: no pointer change, and `ras_underflow` is set.
- A pop after an overflow returns the newest RAS_DEPTH addresses in LIFO order.
- Only one operation per cycle; the encoding makes simultaneous push and pop impossible.
- Sticky flags clear only on `rst`.

## Timing

- Reset, when `rst` is high at an edge:
  - `pc = RESET_PC`, `ras_count = 0`, pointer 0, both flags 0.
  - RAS contents are don't-care.
  - `rst` overrides any concurrent operation, including one mid-CALL.
- After reset, `pc_next` = `RESET_PC + PC_INCR` when `pc_op = SEQ`.
- Latency:
  - `pc_next` is combinational in the same cycle.
  - `pc` reflects it one edge later.
  - A RET issued in the cycle right after a CALL returns that CALL's `seq`; the RAS has no read-after-write bubble.
- A non-fetch stage or `stall = 1` holds all state; `pc_next` is still driven.

## Configuration

- `PC_RAS_EN` defined: the RAS, `ras_count` and both flags are implemented as described.
- `PC_RAS_EN` undefined:
  - No RAS storage.
  - CALL behaves as an unconditional jump to `target`, with no push.
  - RET behaves as SEQ.
  - `ras_count`, `ras_overflow` and `ras_underflow` are tied to 0.

## Test plan

- Reset: assert `rst` with `RESET_PC=0x100` and `PC_INCR=1`, then release. Expect `pc = 0x100`. Then apply SEQ ×3 in fetch; expect `pc = 0x103`.
- JUMP:
  - `jump_cond=1`, `target=0x40` → `pc = 0x40`.
  - `jump_cond=0` → `pc = 0x41`.
  - `pc=0xFFFFFFFF` with SEQ → wraps to 0.
- Gating: at `pc=0x10`, apply CALL `target=0x80` with `stall=1`, or with a non-fetch stage. Expect `pc` to stay `0x10` and `ras_count` to stay 0. Also check `pc_en = 0`.
- Nested call/return:
  - From `pc=0x10`, CALL `0x80` then CALL `0xC0` → `ras_count = 2`.
  - RET → `pc = 0x81`; RET → `pc = 0x11`; `ras_count = 0`.
- Overflow and underflow with `RAS_DEPTH=4`:
  - 5 CALLs from PCs 0, 0x10, 0x20, 0x30, 0x40 → `ras_overflow = 1`, `ras_count = 4`.
  - 4 RETs → `0x41`, `0x31`, `0x21`, `0x11`.
  - A 5th RET → `pc` advances by 1, `ras_underflow = 1`.
  - Assert `rst` → both flags clear.
- `PC_RAS_EN` undefined: CALL `0x80` → `pc = 0x80`, `ras_count = 0`. Then RET → `pc = 0x81`, both flags 0.
